// File: rtl/bcd_a_binario_seq.sv
// rtl/bcd_a_binario_seq.sv - sequential packed-BCD to binary converter, start/done handshake
// Optional signed result when BCD_A_BINARIO_SIGNO_EN is defined.
module bcd_a_binario_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
`ifdef BCD_A_BINARIO_SIGNO_EN
    input  logic                sign_in,
`endif
    output logic                ready,
    output logic                done,
    output logic                err,
`ifdef BCD_A_BINARIO_SIGNO_EN
    output logic [BIN_W:0]      bin_out
`else
    output logic [BIN_W-1:0]    bin_out
`endif
);

`ifdef BCD_A_BINARIO_SIGNO_EN
    localparam int OUT_W = BIN_W + 1;
`else
    localparam int OUT_W = BIN_W;
`endif
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    generate
        if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : g_width_check
            $error("bcd_a_binario_seq: BIN_W too narrow for DIGITS");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] opnd_q, opnd_d;
    logic                err_q, err_d;
    logic [OUT_W-1:0]    bin_q, bin_d;
`ifdef BCD_A_BINARIO_SIGNO_EN
    logic                sign_q, sign_d;
    logic [OUT_W-1:0]    mag;
`endif

    logic                bad_in;
    logic [3:0]          cur_digit;
    logic                last;
    logic [BIN_W-1:0]    acc_next;
    logic [OUT_W-1:0]    result;

    // Invalid nibbles are detected on the live input so the error path skips CONV.
    always_comb begin
        bad_in = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end

    // Counter walks from the most significant nibble downwards.
    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_q == CNT_W'(DIGITS - 1 - k)) begin
                cur_digit = opnd_q[4*k +: 4];
            end
        end
    end

    assign last     = (cnt_q == CNT_W'(DIGITS - 1));
    assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_digit);

`ifdef BCD_A_BINARIO_SIGNO_EN
    assign mag    = {1'b0, acc_next};
    assign result = sign_q ? (~mag + OUT_W'(1)) : mag;
`else
    assign result = acc_next;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        err_d   = err_q;
        bin_d   = bin_q;
`ifdef BCD_A_BINARIO_SIGNO_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opnd_d = bcd_in;
`ifdef BCD_A_BINARIO_SIGNO_EN
                    sign_d = sign_in;
`endif
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (bad_in) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    bin_d   = result;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
`ifdef BCD_A_BINARIO_SIGNO_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
`ifdef BCD_A_BINARIO_SIGNO_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;
    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_a_binario_seq.sv
// tb/tb_bcd_a_binario_seq.sv - bench for bcd_a_binario_seq
`timescale 1ns/1ps
module tb_bcd_a_binario_seq;
    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;
`ifdef BCD_A_BINARIO_SIGNO_EN
    localparam int OUT_W = BIN_W + 1;
`else
    localparam int OUT_W = BIN_W;
`endif

    typedef struct {
        logic [7:0]       bcd;
        logic             sgn;
        logic [OUT_W-1:0] exp_bin;
        logic             exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       bcd_in;
`ifdef BCD_A_BINARIO_SIGNO_EN
    logic             sign_in;
`endif
    logic             ready;
    logic             done;
    logic             err;
    logic [OUT_W-1:0] bin_out;

    int               checks = 0;
    int               errors = 0;
    int               done_cnt = 0;
    int               cyc = 0;
    logic [OUT_W-1:0] last_bin = '0;
    vec_t             exp_q[$];

    bcd_a_binario_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
`ifdef BCD_A_BINARIO_SIGNO_EN
        .sign_in (sign_in),
`endif
        .ready   (ready),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin : mon
        vec_t e;
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bin_out", bin_out, e.exp_bin);
                chk("err", err, e.exp_err);
                chk("ready_in_done", ready, 1'b0);
                last_bin = e.exp_bin;
            end
        end
    end

    task automatic do_conv(input vec_t v);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_start", ready, 1'b1);
        bcd_in = v.bcd;
`ifdef BCD_A_BINARIO_SIGNO_EN
        sign_in = v.sgn;
`endif
        start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_accept", ready, 1'b0);
        chk("err_after_accept", err, v.exp_err);
        chk("bin_hold_at_accept", bin_out, v.exp_err ? '0 : last_bin);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, v.exp_err ? 1 : DIGITS + 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[10];
        vec_t v;
        int   n;
        int   seen;
        int   t1;
        int   t2;
        int   dn0;

        tbl[0] = '{8'h42, 1'b0, 42, 1'b0};
        tbl[1] = '{8'h99, 1'b0, 99, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 0,  1'b0};
        tbl[3] = '{8'h07, 1'b0, 7,  1'b0};
        tbl[4] = '{8'h3A, 1'b0, 0,  1'b1};
        tbl[5] = '{8'h50, 1'b0, 50, 1'b0};
        tbl[6] = '{8'hA0, 1'b0, 0,  1'b1};
        tbl[7] = '{8'h19, 1'b0, 19, 1'b0};
        tbl[8] = '{8'hFF, 1'b0, 0,  1'b1};
        tbl[9] = '{8'h90, 1'b0, 90, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        bcd_in = 8'h00;
`ifdef BCD_A_BINARIO_SIGNO_EN
        sign_in = 1'b0;
`endif
        #2;
        chk("reset_ready", ready, 1'b1);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_bin", bin_out, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_conv(tbl[i]);
        end

        v = '{8'h3A, 1'b0, 0, 1'b1};
        do_conv(v);
        v = '{8'h15, 1'b0, 15, 1'b0};
        do_conv(v);

        // start held high: 99 then 00, one conversion per DIGITS+2 cycles
        bcd_in = 8'h99;
        start = 1'b1;
        v = '{8'h99, 1'b0, 99, 1'b0};
        exp_q.push_back(v);
        v = '{8'h00, 1'b0, 0, 1'b0};
        exp_q.push_back(v);
        @(negedge clk);
        bcd_in = 8'h00;
        seen = 0;
        n = 0;
        t1 = 0;
        t2 = 0;
        while (seen < 2 && n < 30) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen++;
                if (seen == 1) t1 = cyc;
                else t2 = cyc;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", seen, 2);
        chk("b2b_gap", t2 - t1, DIGITS + 2);
        repeat (3) @(negedge clk);

        // start pulsed during CONV must be ignored
        dn0 = done_cnt;
        bcd_in = 8'h27;
        start = 1'b1;
        v = '{8'h27, 1'b0, 27, 1'b0};
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        bcd_in = 8'h81;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("ignored_single_done", done_cnt - dn0, 1);
        chk("ignored_bin_held", bin_out, 27);

        // asynchronous reset mid-conversion
        dn0 = done_cnt;
        bcd_in = 8'h64;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_ready", ready, 1'b1);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_err", err, 1'b0);
        chk("async_rst_bin", bin_out, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_bin = '0;
        repeat (4) @(negedge clk);
        chk("rst_no_done", done_cnt - dn0, 0);
        v = '{8'h05, 1'b0, 5, 1'b0};
        do_conv(v);

`ifdef BCD_A_BINARIO_SIGNO_EN
        v = '{8'h15, 1'b1, 8'hF1, 1'b0};
        do_conv(v);
        v = '{8'h00, 1'b1, 8'h00, 1'b0};
        do_conv(v);
        v = '{8'h3A, 1'b1, 8'h00, 1'b1};
        do_conv(v);
        v = '{8'h99, 1'b1, 8'h9D, 1'b0};
        do_conv(v);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
